res_arb: RTL and testbench

Arbiter and sequencer for the single-port 16384×8 `res` RAM, shared between two requesters: the distance-transform engine (requester 0) and a host load/readback port (requester 1). It sits between both requesters and the RAM pins (`res_wr`, `res_rd`, `res_addr`, `res_do`, `res_di`). It issues at most one RAM command per cycle and tags read returns to the issuing requester. Round-robin arbitration is supported, along with a lock so that the engine can keep ownership across its multi-access neighbourhood sequences.

---
 rtl/res_arb_pkg.sv | 22 ++
 rtl/res_arb_lock_timer.sv | 43 ++++
 rtl/res_arb.sv | 171 +++++++++++++++++
 tb/tb_res_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/res_arb_pkg.sv
// ============================================================================
//  Module      : res_arb_pkg
//  Description : Shared types and constants for the res RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package res_arb_pkg;

  localparam int RES_AW       = 14;
  localparam int RES_DW       = 8;
  localparam int RES_LOCK_MAX = 15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/res_arb_lock_timer.sv
// ============================================================================
//  Module      : res_arb_lock_timer
//  Description : Idle counter that pulses o_release when a locked owner has
//                stayed silent for LOCK_MAX cycles (RES_ARB_LOCK_TIMEOUT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module res_arb_lock_timer
  import res_arb_pkg::*;
#(
  parameter int LOCK_MAX = RES_LOCK_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_req,
  output logic o_release
);

  localparam int CW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);
  localparam logic [CW-1:0] c_cnt_last = CW'(LOCK_MAX - 1);

  logic [CW-1:0] r_cnt;
  logic          w_idle;

  assign w_idle    = i_active && !i_req;
  // Fire on the edge where the count would reach LOCK_MAX.
  assign o_release = w_idle && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_idle || o_release) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/res_arb.sv
// ============================================================================
//  Module      : res_arb
//  Description : Two-requester round-robin/lock arbiter for the single-port
//                res RAM, with tagged read returns.
//                Optional macro: RES_ARB_LOCK_TIMEOUT_EN (idle-lock release).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module res_arb
  import res_arb_pkg::*;
#(
  parameter int AW       = RES_AW,
  parameter int DW       = RES_DW,
  parameter int LOCK_MAX = RES_LOCK_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          res_wr,
  output logic          res_rd,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_do,
  input  logic [DW-1:0] res_di
);

  owner_t        r_owner;
  owner_t        w_owner_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_lock_rel;

  logic          w_acc;
  logic          w_cmd_wr;
  logic [AW-1:0] w_cmd_addr;
  logic [DW-1:0] w_cmd_data;

  logic          r_res_wr;
  logic          r_res_rd;
  logic [AW-1:0] r_res_addr;
  logic [DW-1:0] r_res_do;
  logic          r_s1_vld;
  logic          r_s1_tag;
  logic          r_s2_vld;
  logic          r_s2_tag;

`ifdef RES_ARB_LOCK_TIMEOUT_EN
  logic w_lock_active;
  logic w_owner_req;

  assign w_lock_active = (r_owner != OWN_NONE);
  assign w_owner_req   = (r_owner == OWN_R0) ? req0 : req1;

  res_arb_lock_timer #(
    .LOCK_MAX (LOCK_MAX)
  ) u_lock_timer (
    .clk       (clk),
    .reset     (reset),
    .i_active  (w_lock_active),
    .i_req     (w_owner_req),
    .o_release (w_lock_rel)
  );
`else
  // Without the timer a lock only ends on a lock=0 command; LOCK_MAX is inert.
  assign w_lock_rel = (LOCK_MAX < 0);
`endif

  // Owner / last-winner state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= OWN_NONE;
      r_last  <= 1'b1;
    end else begin
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;

    if (!reset) begin
      case (r_owner)
        OWN_R0:  w_gnt0 = req0;
        OWN_R1:  w_gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
          end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
          end
        end
      endcase
    end

    if (w_gnt0) begin
      w_last_nxt  = 1'b0;
      w_owner_nxt = lock0 ? OWN_R0 : OWN_NONE;
    end else if (w_gnt1) begin
      w_last_nxt  = 1'b1;
      w_owner_nxt = lock1 ? OWN_R1 : OWN_NONE;
    end else if (w_lock_rel) begin
      w_owner_nxt = OWN_NONE;
    end
  end

  assign gnt0       = w_gnt0;
  assign gnt1       = w_gnt1;
  assign w_acc      = w_gnt0 || w_gnt1;
  assign w_cmd_wr   = w_gnt1 ? wr1    : wr0;
  assign w_cmd_addr = w_gnt1 ? addr1  : addr0;
  assign w_cmd_data = w_gnt1 ? wdata1 : wdata0;

  // RAM command register and two-stage read-tag pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_wr   <= 1'b0;
      r_res_rd   <= 1'b0;
      r_res_addr <= '0;
      r_res_do   <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_tag   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_tag   <= 1'b0;
    end else begin
      r_res_wr <= w_acc && w_cmd_wr;
      r_res_rd <= w_acc && !w_cmd_wr;
      if (w_acc) begin
        r_res_addr <= w_cmd_addr;
        r_res_do   <= w_cmd_data;
      end
      r_s1_vld <= w_acc && !w_cmd_wr;
      r_s1_tag <= w_gnt1;
      r_s2_vld <= r_s1_vld;
      r_s2_tag <= r_s1_tag;
    end
  end

  assign res_wr   = r_res_wr;
  assign res_rd   = r_res_rd;
  assign res_addr = r_res_addr;
  assign res_do   = r_res_do;
  assign rvalid0  = r_s2_vld && !r_s2_tag;
  assign rvalid1  = r_s2_vld && r_s2_tag;
  // RAM data arrives in the same cycle the tag leaves stage 2.
  assign rdata    = r_s2_vld ? res_di : '0;

endmodule

`default_nettype wire

// File: tb/tb_res_arb.sv
// ============================================================================
//  Module      : tb_res_arb
//  Description : Self-checking bench for res_arb with a RAM model and a
//                spec-level arbitration reference.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_res_arb;
  import res_arb_pkg::*;

  localparam int AW    = RES_AW;
  localparam int DW    = RES_DW;
  localparam int DEPTH = 1 << AW;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          req0   = 1'b0;
  logic          req1   = 1'b0;
  logic          wr0    = 1'b0;
  logic          wr1    = 1'b0;
  logic          lock0  = 1'b0;
  logic          lock1  = 1'b0;
  logic [AW-1:0] addr0  = '0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, res_wr, res_rd;
  logic [DW-1:0] rdata, res_do;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_di = '0;

  always #5 clk = ~clk;

  res_arb dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .res_wr(res_wr), .res_rd(res_rd), .res_addr(res_addr),
    .res_do(res_do), .res_di(res_di)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i) ^ 8'h84;
  endfunction

  // RAM model: registered read, data valid the cycle after res_rd.
  logic [DW-1:0] ram [DEPTH];
  bit            ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
      ram_loaded <= 1'b1;
    end
    if (res_wr) ram[res_addr] <= res_do;
    if (res_rd) res_di <= ram[res_addr];
  end

  typedef struct {
    bit rst, rq0, rq1, w0, w1, l0, l1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    bit eg0, eg1;
  } vec_t;

  typedef struct {
    int            due;
    bit            tag;
    logic [DW-1:0] data;
  } ret_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            m_owner;   // 0 none, 1 requester 0, 2 requester 1
  bit            m_last;
  int            m_idle;
  bit            m_g0, m_g1;
  logic          e_wr, e_rd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_do;
  logic [DW-1:0] ref_mem [DEPTH];
  ret_t          q[$];
  bit            cap_g1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(bit rq0, bit rq1, bit w0, bit w1, bit l0, bit l1,
                              int a0, int a1, int d0, int d1, bit eg0, bit eg1);
    vec_t v;
    v.rst = 1'b0; v.rq0 = rq0; v.rq1 = rq1; v.w0 = w0; v.w1 = w1;
    v.l0 = l0; v.l1 = l1; v.a0 = AW'(a0); v.a1 = AW'(a1);
    v.d0 = DW'(d0); v.d1 = DW'(d1); v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  function automatic vec_t rst_vec();
    vec_t v;
    v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_last = 1'b1; m_idle = 0;
    e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_do = '0;
    q.delete();
  endtask

  task automatic model_grant();
    m_g0 = 1'b0; m_g1 = 1'b0;
    if (reset) return;
    if (m_owner == 1)      m_g0 = req0;
    else if (m_owner == 2) m_g1 = req1;
    else if (req0 && req1) begin
      if (m_last) m_g0 = 1'b1; else m_g1 = 1'b1;
    end else begin
      m_g0 = req0; m_g1 = req1;
    end
  endtask

  task automatic model_edge();
    bit            n, w, l;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ret_t          r;
    if (m_g0 || m_g1) begin
      n = m_g1;
      w = n ? wr1 : wr0;
      l = n ? lock1 : lock0;
      a = n ? addr1 : addr0;
      d = n ? wdata1 : wdata0;
      m_last  = n;
      m_owner = l ? (n ? 2 : 1) : 0;
      m_idle  = 0;
      e_wr = w; e_rd = !w; e_addr = a; e_do = d;
      if (w) ref_mem[a] = d;
      else begin
        r.due = cyc + 2; r.tag = n; r.data = ref_mem[a];
        q.push_back(r);
      end
    end else begin
      e_wr = 1'b0; e_rd = 1'b0;
`ifdef RES_ARB_LOCK_TIMEOUT_EN
      if (m_owner == 0) m_idle = 0;
      else if ((m_owner == 1) ? req0 : req1) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == RES_LOCK_MAX) begin
          m_owner = 0;
          m_idle  = 0;
        end
      end
`endif
    end
  endtask

  task automatic check_outputs();
    bit            ev0, ev1;
    logic [DW-1:0] ed;
    ev0 = 1'b0; ev1 = 1'b0; ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev0 = !q[0].tag; ev1 = q[0].tag; ed = q[0].data;
      void'(q.pop_front());
    end
    chk("gnt0", 32'(gnt0), 32'(m_g0));
    chk("gnt1", 32'(gnt1), 32'(m_g1));
    chk("res_wr", 32'(res_wr), 32'(e_wr));
    chk("res_rd", 32'(res_rd), 32'(e_rd));
    chk("res_addr", 32'(res_addr), 32'(e_addr));
    chk("res_do", 32'(res_do), 32'(e_do));
    chk("rvalid0", 32'(rvalid0), 32'(ev0));
    chk("rvalid1", 32'(rvalid1), 32'(ev1));
    if (ev0 || ev1) chk("rdata", 32'(rdata), 32'(ed));
    if (reset)      chk("rdata_rst", 32'(rdata), 32'h0);
  endtask

  task automatic run_cycle(input vec_t v, input bit chk_tbl);
    @(negedge clk);
    reset = v.rst; req0 = v.rq0; req1 = v.rq1; wr0 = v.w0; wr1 = v.w1;
    lock0 = v.l0; lock1 = v.l1; addr0 = v.a0; addr1 = v.a1;
    wdata0 = v.d0; wdata1 = v.d1;
    #1;
    if (reset) model_reset();
    model_grant();
    check_outputs();
    cap_g1 = gnt1;
    if (chk_tbl) begin
      chk("tbl_gnt0", 32'(gnt0), 32'(v.eg0));
      chk("tbl_gnt1", 32'(gnt1), 32'(v.eg1));
    end
    @(posedge clk);
    if (!reset) model_edge();
    cyc++;
  endtask

  vec_t idle;
  vec_t tbl [14];
  int   seen;
  int   first;
  int   exp_first;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    model_reset();
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++)
      tbl[i] = mk(1, 1, 0, 0, 0, 0, 10, 20, 0, 0, (i % 2) == 0, (i % 2) == 1);
    for (int i = 4; i < 8; i++)
      tbl[i] = mk(1, 1, 1, 0, 1, 0, 96 + i, 100, i, 0, 1, 0);
    tbl[8]  = mk(1, 1, 1, 0, 0, 0, 104, 100, 9, 0, 1, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 0, 104, 100, 0, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 1, 0, 1, 0, 16383, 0, 8'h3C, 0, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 5, 16383, 0, 0, 0, 1);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 5, 7, 0, 0, 1, 0);

    // Reset state, with requests asserted to show grants are masked.
    run_cycle(rst_vec(), 1'b1);
    run_cycle(rst_vec(), 1'b1);

    // Single read of RAM[129] (pattern value 5).
    run_cycle(mk(1, 0, 0, 0, 0, 0, 129, 0, 0, 0, 1, 0), 1'b1);
    #1;
    chk("single_res_rd", 32'(res_rd), 32'h1);
    chk("single_res_addr", 32'(res_addr), 32'd129);
    run_cycle(idle, 1'b0);
    #1;
    chk("single_rvalid0", 32'(rvalid0), 32'h1);
    chk("single_rdata", 32'(rdata), 32'h5);
    chk("single_rvalid1", 32'(rvalid1), 32'h0);
    run_cycle(idle, 1'b0);

    // Write at the top address.
    run_cycle(mk(0, 1, 0, 1, 0, 0, 0, 16383, 0, 8'hFF, 0, 1), 1'b1);
    #1;
    chk("write_res_wr", 32'(res_wr), 32'h1);
    chk("write_res_addr", 32'(res_addr), 32'd16383);
    chk("write_res_do", 32'(res_do), 32'hFF);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      run_cycle(idle, 1'b0);
      if (rvalid0 || rvalid1) seen++;
    end
    chk("write_no_rvalid", 32'(seen), 32'h0);

    // Contention, lock hold and release, owner-drops-req table.
    run_cycle(rst_vec(), 1'b0);
    for (int i = 0; i < 14; i++) run_cycle(tbl[i], 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(idle, 1'b0);

    // Reset one cycle after a read accept.
    run_cycle(mk(1, 0, 0, 0, 0, 0, 50, 0, 0, 0, 1, 0), 1'b1);
    run_cycle(rst_vec(), 1'b0);
    #1;
    chk("rst_ctl_outs", 32'({gnt0, gnt1, rvalid0, rvalid1, res_wr, res_rd}), 32'h0);
    chk("rst_data_outs", 32'({res_addr, res_do, rdata}), 32'h0);
    run_cycle(rst_vec(), 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(idle, 1'b0);
      #1;
      if (rvalid0 || rvalid1) seen++;
    end
    chk("rst_flush_no_rvalid", 32'(seen), 32'h0);

    // Locked owner goes silent while requester 1 waits.
    run_cycle(rst_vec(), 1'b0);
    run_cycle(mk(1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0), 1'b1);
    first = -1;
    for (int k = 1; k <= 100; k++) begin
      run_cycle(mk(0, 1, 0, 0, 0, 0, 0, k, 0, 0, 0, 0), 1'b0);
      if (first < 0 && cap_g1) first = k;
    end
`ifdef RES_ARB_LOCK_TIMEOUT_EN
    exp_first = RES_LOCK_MAX + 1;
`else
    exp_first = -1;
`endif
    chk("timeout_first_gnt1", 32'(first), 32'(exp_first));

    // Randomized traffic against the reference model.
    run_cycle(rst_vec(), 1'b0);
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 63)),
             int'($urandom_range(0, 63)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0);
      v.rst = ($urandom_range(0, 399) == 0);
      run_cycle(v, 1'b0);
    end
    for (int i = 0; i < 4; i++) run_cycle(idle, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
